// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - instruction field layout, NOP encoding and register-operand decode
//
// Purpose: shared ISA definitions for the issue stage.
//   Field layout: [31:29] ALUOp, [28] DataSource (1 = immediate), [27] WriteEnable,
//   [26:22] WriteSelect, [21:17] ReadSelect1, [15:11] ReadSelect2, [15:0] Immediate.
//   Bit 16 is unused.
// Ports: none (package).
package isa_pkg;

  localparam int ALUOP_MSB = 31;
  localparam int ALUOP_LSB = 29;
  localparam int DSRC_BIT  = 28;
  localparam int WE_BIT    = 27;
  localparam int WSEL_MSB  = 26;
  localparam int WSEL_LSB  = 22;
  localparam int RS1_MSB   = 21;
  localparam int RS1_LSB   = 17;
  localparam int RS2_MSB   = 15;
  localparam int RS2_LSB   = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic       we;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
  } instr_regs_t;

  // One history slot: what an issued word will eventually write.
  typedef struct packed {
    logic       we;
    logic [4:0] rd;
  } hist_t;

  // ReadSelect2 shares bits with the immediate, so it only counts as a
  // register read when DataSource selects the register operand.
  function automatic instr_regs_t decode_regs(input logic [31:0] instr);
    instr_regs_t r;
    r.we       = instr[WE_BIT];
    r.rd       = instr[WSEL_MSB:WSEL_LSB];
    r.rs1      = instr[RS1_MSB:RS1_LSB];
    r.rs2      = instr[RS2_MSB:RS2_LSB];
    r.uses_rs2 = !instr[DSRC_BIT];
    return r;
  endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// rtl/instr_issue_unit_if.sv - loader/pipeline-facing signal bundle of the issue stage
//
// Purpose: groups the loader handshake, the pipeline instruction output and FIFO status.
// Signals:
//   InstrIn[31:0], InstrValid  loader -> issue unit
//   InstrReady                 issue unit -> loader (equals !Full)
//   Out[31:0], Issued          registered instruction / real-instruction flag
//   Count, Full, Empty         FIFO occupancy and status
// Modports: master (loader/observer side), slave (issue unit side).
interface instr_issue_unit_if #(
  parameter int DEPTH = 8
);

  logic [31:0]              InstrIn;
  logic                     InstrValid;
  logic                     InstrReady;
  logic [31:0]              Out;
  logic                     Issued;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Full;
  logic                     Empty;

  modport master (
    output InstrIn, InstrValid,
    input  InstrReady, Out, Issued, Count, Full, Empty
  );

  modport slave (
    input  InstrIn, InstrValid,
    output InstrReady, Out, Issued, Count, Full, Empty
  );

endinterface

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - DEPTH x 32 synchronous FIFO with occupancy count
//
// Purpose: instruction buffer between loader and issue logic.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push_i, wdata_i   write request and data (ignored when full)
//   pop_i             read-advance request (ignored when empty)
//   rdata_o           head entry (valid when !empty_o)
//   count_o           occupancy, 0..DEPTH
//   full_o, empty_o   status, derived from registered count
module instr_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [31:0]   wdata_i,
  input  logic          pop_i,
  output logic [31:0]   rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE        = (AW+1)'(1);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;  // power-of-two depth wraps naturally
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_issue_unit.sv
// rtl/instr_issue_unit.sv - in-order issue stage with RAW bubble insertion
//
// Purpose: buffers loader instructions and issues at most one per cycle to a
//   three-stage pipeline without forwarding. A result becomes readable three
//   issue slots after its producer, so the head waits while either of the last
//   two issued words writes a register it reads.
// Build option: HAZARD_STALL_EN - when defined, history and hazard comparators
//   are present; when undefined the head issues every non-empty cycle.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       instr_issue_unit_if.slave (InstrIn/InstrValid/InstrReady,
//             Out/Issued, Count/Full/Empty)
module instr_issue_unit
  import isa_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  instr_issue_unit_if.slave   bus
);

  logic [31:0] head;
  logic [AW:0] count;
  logic        full, empty;
  logic        push, pop, hazard;
  logic [31:0] out_q, out_d;
  logic        issued_q;

  assign push = bus.InstrValid && !full;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus.InstrIn),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef HAZARD_STALL_EN
  // hist0_q describes the word currently on Out, hist1_q the one before it.
  hist_t       hist0_q, hist1_q;
  instr_regs_t head_regs;

  function automatic logic reads_dest(input hist_t h, input instr_regs_t r);
    return h.we && ((h.rd == r.rs1) || (r.uses_rs2 && (h.rd == r.rs2)));
  endfunction

  assign head_regs = decode_regs(head);
  assign hazard    = !empty && (reads_dest(hist0_q, head_regs) ||
                                reads_dest(hist1_q, head_regs));

  always_ff @(posedge clk) begin
    if (rst) begin
      hist0_q <= '0;
      hist1_q <= '0;
    end else begin
      hist1_q <= hist0_q;
      hist0_q <= pop ? hist_t'{we: head_regs.we, rd: head_regs.rd} : '0;
    end
  end
`else
  assign hazard = 1'b0;
`endif

  assign pop   = !empty && !hazard;
  assign out_d = pop ? head : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= NOP_INSTR;
      issued_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      issued_q <= pop;
    end
  end

  assign bus.Out        = out_q;
  assign bus.Issued     = issued_q;
  assign bus.Count      = count;
  assign bus.Full       = full;
  assign bus.Empty      = empty;
  assign bus.InstrReady = !full;

endmodule

// File: tb/tb_instr_issue_unit.sv
// tb/tb_instr_issue_unit.sv - self-checking bench for instr_issue_unit
module tb_instr_issue_unit;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  instr_issue_unit_if #(.DEPTH(DEPTH)) bus ();

  instr_issue_unit #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: pending words as a queue, plus the last two Out words.
  logic [31:0] mq [$];
  logic [31:0] m_out  = 32'h0;
  logic [31:0] m_prev = 32'h0;
  logic        m_iss  = 1'b0;
  logic [31:0] trace [$];

  // Consumer c reads a register that producer p writes.
  function automatic bit dep(input logic [31:0] c, input logic [31:0] p);
    logic [4:0] rd;
    rd = p[26:22];
    return p[27] && ((rd == c[21:17]) || (!c[28] && rd == c[15:11]));
  endfunction

  function automatic logic [31:0] mk(input bit we, input int rd, input int rs1,
                                     input int rs2, input bit ds);
    logic [31:0] w;
    w = 32'h0;
    w[31:29] = 3'b010;
    w[28]    = ds;
    w[27]    = we;
    w[26:22] = rd[4:0];
    w[21:17] = rs1[4:0];
    w[15:11] = rs2[4:0];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out",    bus.Out, m_out);
    chk("issued", 32'(bus.Issued), 32'(m_iss));
    chk("count",  32'(bus.Count), 32'(mq.size()));
    chk("empty",  32'(bus.Empty), 32'(mq.size() == 0));
    chk("full",   32'(bus.Full), 32'(mq.size() == DEPTH));
    chk("ready",  32'(bus.InstrReady), 32'(mq.size() != DEPTH));
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] d);
    bit push_ok, issue, stall;
    @(negedge clk);
    rst = r;
    bus.InstrValid = v;
    bus.InstrIn = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_out = 32'h0;
      m_prev = 32'h0;
      m_iss = 1'b0;
    end else begin
      push_ok = v && (mq.size() < DEPTH);
      stall = 1'b0;
`ifdef HAZARD_STALL_EN
      if (mq.size() > 0) stall = dep(mq[0], m_out) || dep(mq[0], m_prev);
`endif
      issue = (mq.size() > 0) && !stall;
      m_prev = m_out;
      m_out = issue ? mq.pop_front() : 32'h0;
      m_iss = issue;
      if (push_ok) mq.push_back(d);
    end
    #1;
    check_all();
    trace.push_back(bus.Out);
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] exp [$]);
    chk({tag, "_len_ok"}, 32'(trace.size() >= exp.size()), 32'd1);
    for (int i = 0; i < exp.size() && i < trace.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), trace[i], exp[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] a, b, c, w;
    logic [31:0] ex [$];
    logic [31:0] ind [4];

    bus.InstrValid = 1'b0;
    bus.InstrIn = 32'h0;

    // Reset state
    step(1'b1, 1'b0, 32'h0);
    chk("rst_out",    bus.Out, 32'h0);
    chk("rst_issued", 32'(bus.Issued), 32'd0);
    chk("rst_count",  32'(bus.Count), 32'd0);
    chk("rst_empty",  32'(bus.Empty), 32'd1);
    chk("rst_full",   32'(bus.Full), 32'd0);
    chk("rst_ready",  32'(bus.InstrReady), 32'd1);

    // Four independent ops back-to-back
    for (int i = 0; i < 4; i++) ind[i] = mk(1'b1, i + 1, 10, 11, 1'b0);
    trace.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, ind[i]);
    idle(2);
    ex = '{32'h0, ind[0], ind[1], ind[2], ind[3], 32'h0};
    chk_seq("indep", ex);

    // Distance-1 dependence
    a = mk(1'b1, 5, 10, 11, 1'b0);
    b = mk(1'b1, 6, 5, 12, 1'b0);
    trace.delete();
    step(1'b0, 1'b1, a);
    step(1'b0, 1'b1, b);
    idle(4);
`ifdef HAZARD_STALL_EN
    ex = '{32'h0, a, 32'h0, 32'h0, b, 32'h0};
`else
    ex = '{32'h0, a, b, 32'h0, 32'h0, 32'h0};
`endif
    chk_seq("dist1", ex);

    // Distance-2 dependence through ReadSelect2
    a = mk(1'b1, 7, 10, 11, 1'b0);
    c = mk(1'b1, 8, 10, 11, 1'b0);
    b = mk(1'b1, 9, 12, 7, 1'b0);
    trace.delete();
    step(1'b0, 1'b1, a);
    step(1'b0, 1'b1, c);
    step(1'b0, 1'b1, b);
    idle(3);
`ifdef HAZARD_STALL_EN
    ex = '{32'h0, a, c, 32'h0, b, 32'h0};
`else
    ex = '{32'h0, a, c, b, 32'h0, 32'h0};
`endif
    chk_seq("dist2", ex);

    // Immediate operand: bits [15:11]=7 are not a register read
    b = mk(1'b1, 9, 12, 7, 1'b1);
    trace.delete();
    step(1'b0, 1'b1, a);
    step(1'b0, 1'b1, c);
    step(1'b0, 1'b1, b);
    idle(3);
    ex = '{32'h0, a, c, b, 32'h0, 32'h0};
    chk_seq("imm", ex);

    // Dependency chain fills the FIFO (only stalls when hazards are enabled),
    // then drains across the pointer wrap.
    for (int i = 1; i <= 2 * DEPTH; i++) step(1'b0, 1'b1, mk(1'b1, i + 1, i, 0, 1'b1));
    idle(4 * DEPTH);

    // Reset mid-stream with words queued, then a dependent pair must see no stale history.
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, mk(1'b1, 20 + i, 19 + i, 0, 1'b1));
    a = mk(1'b1, 5, 10, 11, 1'b0);
    step(1'b0, 1'b1, a);
    step(1'b1, 1'b0, 32'h0);
    chk("mid_rst_count",  32'(bus.Count), 32'd0);
    chk("mid_rst_out",    bus.Out, 32'h0);
    chk("mid_rst_issued", 32'(bus.Issued), 32'd0);
    b = mk(1'b1, 6, 5, 12, 1'b0);
    trace.delete();
    step(1'b0, 1'b1, b);
    idle(2);
    ex = '{32'h0, b, 32'h0};
    chk_seq("post_rst", ex);

    // Randomized traffic with small register numbers to provoke hazards
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      w[26:22] = 5'($urandom_range(0, 3));
      w[21:17] = 5'($urandom_range(0, 3));
      w[15:11] = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) < 7), w);
    end
    idle(4 * DEPTH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
